dma_apb_arbiter: RTL

// - Shares one APB channel (DMA->APB request FIFO, APB->DMA response FIFO) between NREQ DMA requesters in the aclk domain.
// - Round-robin grant, held for a whole burst; tracks outstanding reads and returns read data to the issuing requester.
// - Handles abort with flush/discard. Sits between the DMA engines and the APB channel write/read FIFO ports.

---
 rtl/dma_pkg.sv | 25 ++
 rtl/dma_apb_tag_fifo.sv | 55 +++++
 rtl/dma_apb_arbiter.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/dma_pkg.sv
// Shared types and default widths for the DMA-to-APB channel arbiter.
// The request struct is sized from the default widths below.
package dma_pkg;

    localparam int unsigned NREQ_DEF       = 4;
    localparam int unsigned APB_SVL_DEF    = 4;
    localparam int unsigned ADDR_W_DEF     = 16;
    localparam int unsigned DATA_W_DEF     = 16;
    localparam int unsigned MAX_RD_OUT_DEF = 8;
    localparam int unsigned SEL_W_DEF      = $clog2(APB_SVL_DEF);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        ABORT
    } arb_state_t;

    typedef struct packed {
        logic                  write;
        logic [SEL_W_DEF-1:0]  sel;
        logic [DATA_W_DEF-1:0] data;
        logic [ADDR_W_DEF-1:0] addr;
    } apb_req_t;

endpackage

// File: rtl/dma_apb_tag_fifo.sv
// Synchronous FIFO holding the requester index of every outstanding read.
// The head is visible combinationally, so the pop takes effect in the same cycle.
module dma_apb_tag_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 2
) (
    input  logic                     aclk,
    input  logic                     areset,
    input  logic                     i_clear,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [PW:0]      r_count;

    always_ff @(posedge aclk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset || i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (i_push && !i_pop) begin
                r_count <= r_count + 1'b1;
            end else if (i_pop && !i_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

endmodule

// File: rtl/dma_apb_arbiter.sv
// Round-robin arbiter sharing one APB request/response FIFO pair between NREQ DMA
// requesters; grants are held per burst and read data is routed back by tag.
module dma_apb_arbiter
    import dma_pkg::*;
#(
    parameter int unsigned NREQ           = NREQ_DEF,
    parameter int unsigned APB_SVL        = APB_SVL_DEF,
    parameter int unsigned APB_ADDR_WIDTH = ADDR_W_DEF,
    parameter int unsigned APB_DATA_WIDTH = DATA_W_DEF,
    parameter int unsigned MAX_RD_OUT     = MAX_RD_OUT_DEF
) (
    input  logic                                 aclk,
    input  logic                                 areset,
    input  logic                                 aenable,
    input  logic                                 i_abort,
    input  logic [NREQ-1:0]                      i_req_valid,
    input  logic [NREQ-1:0]                      i_req_last,
    input  logic [NREQ-1:0]                      i_req_write,
    input  logic [NREQ*$clog2(APB_SVL)-1:0]      i_req_sel,
    input  logic [NREQ*APB_DATA_WIDTH-1:0]       i_req_data,
    input  logic [NREQ*APB_ADDR_WIDTH-1:0]       i_req_addr,
    output logic [NREQ-1:0]                      o_req_ready,
    output logic [NREQ-1:0]                      o_rsp_valid,
    output logic [APB_DATA_WIDTH-1:0]            o_rsp_data,
    output logic                                 o_wr_valid,
    output logic                                 o_write,
    output logic [$clog2(APB_SVL)-1:0]           o_sel,
    output logic [APB_DATA_WIDTH-1:0]            o_data,
    output logic [APB_ADDR_WIDTH-1:0]            o_addr,
    input  logic                                 i_wr_full,
    input  logic                                 i_rd_empty,
    input  logic [APB_DATA_WIDTH-1:0]            i_data,
    output logic                                 o_rd_valid,
    output logic                                 o_abort
);

    localparam int unsigned SW = $clog2(APB_SVL);
    localparam int unsigned GW = $clog2(NREQ);
    localparam int unsigned CW = $clog2(MAX_RD_OUT) + 1;

    arb_state_t          r_state, w_state_nxt;
    logic [GW-1:0]       r_rr_ptr, w_rr_nxt;
    logic [GW-1:0]       r_grant, w_grant_nxt;
    logic                r_abort;
    logic [GW-1:0]       w_pick, w_idx;
    logic                w_found;
    logic                w_act, w_accept, w_room, w_rsp_pop, w_tag_empty, w_tag_clear;
    logic [GW-1:0]       w_tag;
    logic [CW-1:0]       w_rd_cnt;
    apb_req_t            w_req;

    logic [SW-1:0]             w_sel_arr  [NREQ];
    logic [APB_DATA_WIDTH-1:0] w_data_arr [NREQ];
    logic [APB_ADDR_WIDTH-1:0] w_addr_arr [NREQ];

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
        assign w_sel_arr[gi]  = i_req_sel[gi*SW +: SW];
        assign w_data_arr[gi] = i_req_data[gi*APB_DATA_WIDTH +: APB_DATA_WIDTH];
        assign w_addr_arr[gi] = i_req_addr[gi*APB_ADDR_WIDTH +: APB_ADDR_WIDTH];
    end

    always_comb begin
        w_req.write = i_req_write[r_grant];
        w_req.sel   = w_sel_arr[r_grant];
        w_req.data  = w_data_arr[r_grant];
        w_req.addr  = w_addr_arr[r_grant];
    end

    assign w_act       = aenable && !areset;
    assign w_tag_clear = aenable && (r_state == ABORT);
    assign w_rsp_pop   = w_act && (r_state != ABORT) && !i_rd_empty && !w_tag_empty;
    // A response retiring this cycle frees a slot for a read issued in the same cycle.
    assign w_room      = (w_rd_cnt < CW'(MAX_RD_OUT)) || w_rsp_pop;
    assign w_accept    = w_act && (r_state == BUSY) && !i_abort && i_req_valid[r_grant]
                         && !i_wr_full && (w_req.write || w_room);

    always_comb begin
        w_pick  = r_rr_ptr;
        w_found = 1'b0;
        w_idx   = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            w_idx = GW'((32'(r_rr_ptr) + i) % NREQ);
            if (!w_found && i_req_valid[w_idx]) begin
                w_pick  = w_idx;
                w_found = 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_rr_nxt    = r_rr_ptr;
        w_grant_nxt = r_grant;
        if (i_abort) begin
            w_state_nxt = ABORT;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        w_state_nxt = BUSY;
                        w_grant_nxt = w_pick;
                    end
                end
                BUSY: begin
                    if (w_accept && i_req_last[r_grant]) begin
                        w_state_nxt = IDLE;
                        w_rr_nxt    = (r_grant == GW'(NREQ - 1)) ? '0 : r_grant + 1'b1;
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state  <= IDLE;
            r_rr_ptr <= '0;
            r_grant  <= '0;
            r_abort  <= 1'b0;
        end else if (aenable) begin
            r_state  <= w_state_nxt;
            r_rr_ptr <= w_rr_nxt;
            r_grant  <= w_grant_nxt;
            r_abort  <= i_abort;
        end
    end

    dma_apb_tag_fifo #(
        .DEPTH (MAX_RD_OUT),
        .WIDTH (GW)
    ) u_tag_fifo (
        .aclk    (aclk),
        .areset  (areset),
        .i_clear (w_tag_clear),
        .i_push  (w_accept && !w_req.write),
        .i_data  (r_grant),
        .i_pop   (w_rsp_pop),
        .o_data  (w_tag),
        .o_empty (w_tag_empty),
        .o_count (w_rd_cnt)
    );

    always_comb begin
        o_req_ready          = '0;
        o_req_ready[r_grant] = w_accept;
        o_rsp_valid          = '0;
        o_rsp_valid[w_tag]   = w_rsp_pop;
        o_rsp_data           = w_rsp_pop ? i_data : '0;
        o_wr_valid           = w_accept;
        o_write              = areset ? 1'b0 : w_req.write;
        o_sel                = areset ? '0 : w_req.sel;
        o_data               = areset ? '0 : w_req.data;
        o_addr               = areset ? '0 : w_req.addr;
        o_rd_valid           = w_rsp_pop || (w_act && (r_state == ABORT) && !i_rd_empty);
        o_abort              = r_abort;
    end

endmodule
